// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Each entry is a packed {pc, instr} record.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_ring.sv
// Entry storage: PC written at issue (tail), instr written on response (fill), combinational read at head.
// Zero-latency read; no flow control of its own, and all contents clear on reset.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_wen,
  input  logic [IW-1:0]   pc_idx,
  input  logic [XLEN-1:0] pc_wdata,
  input  logic            instr_wen,
  input  logic [IW-1:0]   instr_idx,
  input  logic [XLEN-1:0] instr_wdata,
  input  logic [IW-1:0]   rd_idx,
  output entry_t          rd_entry
);
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      if (pc_wen)    pc_mem[pc_idx]       <= pc_wdata;
      if (instr_wen) instr_mem[instr_idx] <= instr_wdata;
    end
  end

  assign rd_entry.pc    = pc_mem[rd_idx];
  assign rd_entry.instr = instr_mem[rd_idx];
endmodule

// File: rtl/fetch_queue.sv
// In-order prefetch queue owning the fetch PC; grant->rvalid->out_valid one cycle after response.
// Stops requesting when allocated slots plus pending stale responses reach DEPTH; out_ready low stalls dequeue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic [31:0] out_instr
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = DEPTH[PW:0];

  logic [PW-1:0]   tail, fill, head, drop;
  logic [XLEN-1:0] fetch_pc;
  logic            npc_live;
  logic [PW-1:0]   alloc, inflight;
  logic [PW:0]     budget;
  logic            issue, enq, deq;
  entry_t          head_entry;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign alloc    = tail - head;
  assign inflight = tail - fill;
  assign budget   = {1'b0, alloc} + {1'b0, drop};

  assign imem_req  = !rst && !redirect_valid && (budget < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign out_valid = (fill != head);

  assign issue = imem_req && imem_gnt;
  assign enq   = imem_rvalid && (drop == '0) && !redirect_valid;
  assign deq   = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tail     <= '0;
      fill     <= '0;
      head     <= '0;
      drop     <= '0;
      npc_live <= 1'b0;
    end else if (redirect_valid) begin
      // Everything issued but not yet returned becomes stale; a response arriving now is consumed here.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      tail     <= '0;
      fill     <= '0;
      head     <= '0;
      drop     <= drop + inflight - {{(PW-1){1'b0}}, imem_rvalid};
    end else begin
      if (issue) begin
        tail     <= tail + 1'b1;
        fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        npc_live <= 1'b1;
      end
      if (imem_rvalid) begin
        if (drop != '0) drop <= drop - 1'b1;
        else            fill <= fill + 1'b1;
      end
      if (deq) head <= head + 1'b1;
    end
  end

  fetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst         (rst),
    .pc_wen      (issue),
    .pc_idx      (tail[IW-1:0]),
    .pc_wdata    (fetch_pc),
    .instr_wen   (enq),
    .instr_idx   (fill[IW-1:0]),
    .instr_wdata (imem_rdata),
    .rd_idx      (head[IW-1:0]),
    .rd_entry    (head_entry)
  );

  // out_npc reads as zero until the first PC has been written into storage.
  assign out_pc    = head_entry.pc;
  assign out_npc   = npc_live ? head_entry.pc + XLEN'(INSTR_BYTES) : '0;
  assign out_instr = head_entry.instr;
endmodule
